// File: rtl/wavegen_ctrl_pkg.sv
// Shared splitter/combiner definitions: block geometry, FSM encoding, block-slice helper.
// Both ends of the link import this so the block-to-bit mapping cannot diverge.
package wavegen_ctrl_pkg;

   localparam int WORD_W     = 16;
   localparam int NUM_BLOCKS = 64;
   localparam int ADDR_W     = $clog2(NUM_BLOCKS);
   localparam int IMG_W      = WORD_W * NUM_BLOCKS;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [IMG_W-1:0]  image_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic word_t block_slice(input image_t img, input addr_t k);
      return img[WORD_W*k +: WORD_W];
   endfunction

endpackage

// File: rtl/control_splitter_if.sv
// Narrow block-write link: one (signal, blockaddress) beat per write&&ready.
// The master holds write and payload stable until ready is seen.
interface control_splitter_if;
   import wavegen_ctrl_pkg::*;

   word_t signal;
   addr_t blockaddress;
   logic  write;
   logic  ready;

   modport master (output signal, output blockaddress, output write, input ready);
   modport slave  (input signal, input blockaddress, input write, output ready);

endinterface

// File: rtl/control_block_select.sv
// NUM_BLOCKS:1 block mux from an image and a block index; purely combinational.
// Latency: none; no handshake (feeds the splitter's signal register).
module control_block_select
   import wavegen_ctrl_pkg::*;
(
   input  image_t shadow,
   input  addr_t  cur,
   output word_t  blk
);

   assign blk = block_slice(shadow, cur);

endmodule

// File: rtl/control_splitter.sv
// Streams blocks [first_block..last_block] of a captured control image over the block-write link.
// Latency: first beat valid the cycle after start is accepted; backpressure: payload held while ready=0.
module control_splitter
   import wavegen_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  image_t combinedin,
   input  logic   start,
   input  addr_t  first_block,
   input  addr_t  last_block,
   output logic   busy,
   output logic   done,
   output logic   range_err,
   control_splitter_if.master bus
);

   state_t state;
   image_t shadow;
   addr_t  cur;
   addr_t  end_blk;
   word_t  sig_q;
   logic   write_q;

   image_t sel_img;
   addr_t  sel_addr;
   word_t  mux_out;
   logic   accept;

   assign accept = (state == IDLE) && start && (first_block <= last_block);

   // In IDLE the mux looks straight at the incoming image so the first block
   // is registered on the same edge that captures the shadow.
   always_comb begin
      sel_img  = shadow;
      sel_addr = cur + addr_t'(1);
      if (state == IDLE) begin
         sel_img  = combinedin;
         sel_addr = first_block;
      end
   end

   control_block_select u_block_select (
      .shadow (sel_img),
      .cur    (sel_addr),
      .blk    (mux_out)
   );

   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         shadow <= combinedin;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         write_q   <= 1'b0;
         sig_q     <= '0;
         cur       <= '0;
         end_blk   <= '0;
         done      <= 1'b0;
         range_err <= 1'b0;
      end else begin
         done      <= 1'b0;
         range_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cur     <= first_block;
                  end_blk <= last_block;
                  sig_q   <= mux_out;
                  write_q <= 1'b1;
                  busy    <= 1'b1;
                  state   <= SEND;
               end else if (start) begin
                  range_err <= 1'b1;
               end
            end
            SEND: begin
               // Compare before increment so the last block never wraps cur.
               if (bus.ready) begin
                  if (cur == end_blk) begin
                     write_q <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     cur   <= cur + addr_t'(1);
                     sig_q <= mux_out;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.signal       = sig_q;
   assign bus.blockaddress = cur;
   assign bus.write        = write_q;

endmodule
